ctr_cfg_arb: RTL
================

# ctr_cfg_arb

Two-requester configuration sequencer for a cog counter. It accepts counter-programming requests carrying new mode (CTR), frequency (FRQ) and phase (PHS) words plus a write mask. It arbitrates between the requesters round-robin and drives the counter's `setctr`/`setfrq`/`setphs` strobes and shared `data` bus in a fixed safe order. It sits between the cog instruction path (requester 0) and a hub/debug host (requester 1) and the counter block.

## Interface
- `QUIESCE`, default 1: when 1, any request writing CTR first writes CTR=0 to stop accumulation during reprogramming.
- `clk_cog`  in  1  cog clock; all state changes on rising edge.
- `res`  in  1  synchronous, active-high reset.
- `req`  in  [1:0]  request per requester; held until its `ack`.
- `req_mask`  in  [1:0][2:0]  per-requester write mask: bit2 CTR, bit1 FRQ, bit0 PHS.
- `req_ctr`, `req_frq`, `req_phs`  in  [1:0][31:0]  per-requester words.
- `ack`  out  [1:0]  one-cycle completion pulse to the served requester.
- `busy`  out  1  high whenever state is not IDLE.
- `gnt`  out  1  index of the requester being served; 0 when idle.
- `setctr`, `setfrq`, `setphs`  out  1  write strobes to the counter.
- `data`  out  32  write data to the counter; 0 when no strobe is active.

## Operation
- States: IDLE, OFF, FRQ, PHS, CTR, ACK.
- IDLE: if `req` != 0, grant one requester and latch its mask and three words into shadow registers. Go to the first state whose condition holds, in this order:
  - OFF: mask.CTR and QUIESCE.
  - FRQ: mask.FRQ.
  - PHS: mask.PHS.
  - CTR: mask.CTR.
  - ACK: always reached last.
- After each state, advance to the next state in that order whose condition holds.
- Strobes are a Moore decode of the state register:
  - OFF: `setctr`=1, `data`=0.
  - FRQ: `setfrq`=1, `data`=shadow FRQ.
  - PHS: `setphs`=1, `data`=shadow PHS.
  - CTR: `setctr`=1, `data`=shadow CTR.
  - All other states: strobes 0 and `data` 0.
  - At most one strobe is high in any cycle.
- ACK: `ack[gnt]`=1 for one cycle, then return to IDLE. Update the round-robin pointer to prefer the other requester.
- Arbitration:
  - Only one requester active: grant it.
  - Both active: grant the pointer's preferred requester.
  - After reset the pointer prefers requester 0.
- Operands are latched at grant. Input changes or `req` deassertion mid-sequence do not alter the sequence, and `ack` still pulses.
- A requester still asserting `req` in the cycle after its `ack` is treated as a new request.
- Mask 000: IDLE → ACK directly; no strobes.
- Reset mid-sequence: the next state is IDLE and no `ack` is issued. Counter registers already written keep their values; the requester must re-request.

## Timing
- Reset values: state IDLE, `ack`=0, `busy`=0, `gnt`=0, all strobes 0, `data`=0, pointer=0, shadow registers 0.
- Grant sampled in cycle T0 (IDLE). The first strobe is at T1, one state per cycle after that.
- Full mask, QUIESCE=1: OFF T1, FRQ T2, PHS T3, CTR T4, ACK T5, IDLE T6. Worst-case latency is 5 cycles from request to `ack`.
- A new grant is possible no earlier than the IDLE cycle after ACK, so back-to-back requests are spaced by (active states + 2) cycles.
- The counter captures on the clock edge ending each strobe cycle.

## Structure
- Package `ctr_cfg_pkg`:
  - state enum `ctr_cfg_state_t` (IDLE, OFF, FRQ, PHS, CTR, ACK);
  - mask bit constants `M_PHS`=0, `M_FRQ`=1, `M_CTR`=2.
- Sub-module `rr_arb2`: two-input round-robin picker. Inputs `req[1:0]`, pointer, and an update strobe; outputs grant index and a valid flag.
- The FSM, shadow registers and output decode live in the top module.

## Test plan
- Reset: hold `res` for 2 cycles with `req`=11 → all outputs 0 during reset; req0 is granted in the first IDLE cycle after reset.
- req0, mask 111, ctr=0x1000_0005, frq=1, phs=0x100, QUIESCE=1 → T1 `setctr` data 0; T2 `setfrq` 1; T3 `setphs` 0x100; T4 `setctr` 0x1000_0005; T5 `ack`=01; `busy` high T1–T5.
- req0, mask 010, frq=0x20 → T1 `setfrq` data 0x20, T2 `ack`=01, with no OFF state. Mask 000 → `ack` at T1 and no strobes.
- Both requesters held continuously, mask 001 → grants alternate 0,1,0,1. Each `ack` arrives 3 cycles after the previous one: T0 grant, T1 PHS, T2 ACK, T3 IDLE.
- req1 dropped and its words changed at T2 of a mask-111 sequence → the original latched values still appear on `data`, and `ack`=10 at T5.
- `res` asserted at T3 of a mask-111 sequence → IDLE at T4 with no `ack` and no further strobes; prior FRQ/OFF writes are not undone.

Source files
------------

// File: rtl/ctr_cfg_pkg.sv
// rtl/ctr_cfg_pkg.sv - shared types, mask bit positions and step ordering for ctr_cfg_arb
package ctr_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        OFF  = 3'd1,
        FRQ  = 3'd2,
        PHS  = 3'd3,
        CTR  = 3'd4,
        ACK  = 3'd5
    } ctr_cfg_state_t;

    localparam int M_PHS = 0;
    localparam int M_FRQ = 1;
    localparam int M_CTR = 2;

    // Next step of the fixed write order OFF -> FRQ -> PHS -> CTR -> ACK,
    // skipping steps whose mask condition does not hold.
    function automatic ctr_cfg_state_t next_step(
        input ctr_cfg_state_t cur,
        input logic [2:0]     mask,
        input logic           quiesce
    );
        ctr_cfg_state_t nxt;
        nxt = ACK;
        case (cur)
            IDLE: begin
                if (mask[M_CTR] && quiesce) nxt = OFF;
                else if (mask[M_FRQ])       nxt = FRQ;
                else if (mask[M_PHS])       nxt = PHS;
                else if (mask[M_CTR])       nxt = CTR;
                else                        nxt = ACK;
            end
            OFF: begin
                if (mask[M_FRQ])      nxt = FRQ;
                else if (mask[M_PHS]) nxt = PHS;
                else if (mask[M_CTR]) nxt = CTR;
                else                  nxt = ACK;
            end
            FRQ: begin
                if (mask[M_PHS])      nxt = PHS;
                else if (mask[M_CTR]) nxt = CTR;
                else                  nxt = ACK;
            end
            PHS: begin
                if (mask[M_CTR]) nxt = CTR;
                else             nxt = ACK;
            end
            CTR:     nxt = ACK;
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ctr_cfg_arb_rr_arb2.sv
// rtl/ctr_cfg_arb_rr_arb2.sv - two-input round-robin picker
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    input  logic       upd_i,
    output logic       gnt_o,
    output logic       vld_o
);

    // A lone requester always wins; a tie goes to the pointer's preference.
    // upd_i marks the cycle in which the caller is able to take a grant.
    always_comb begin
        gnt_o = 1'b0;
        case (req_i)
            2'b01:   gnt_o = 1'b0;
            2'b10:   gnt_o = 1'b1;
            2'b11:   gnt_o = ptr_i;
            default: gnt_o = 1'b0;
        endcase
        vld_o = upd_i & (|req_i);
    end

endmodule

// File: rtl/ctr_cfg_arb.sv
// rtl/ctr_cfg_arb.sv - two-requester counter programming sequencer
module ctr_cfg_arb
    import ctr_cfg_pkg::*;
#(
    parameter bit QUIESCE = 1'b1
) (
    input  logic             clk_cog,
    input  logic             res,
    input  logic [1:0]       req,
    input  logic [1:0][2:0]  req_mask,
    input  logic [1:0][31:0] req_ctr,
    input  logic [1:0][31:0] req_frq,
    input  logic [1:0][31:0] req_phs,
    output logic [1:0]       ack,
    output logic             busy,
    output logic             gnt,
    output logic             setctr,
    output logic             setfrq,
    output logic             setphs,
    output logic [31:0]      data
);

    ctr_cfg_state_t state_q, state_d;
    logic           gnt_q, gnt_d;
    logic           ptr_q, ptr_d;
    logic [2:0]     mask_q, mask_d;
    logic [31:0]    ctr_q, ctr_d;
    logic [31:0]    frq_q, frq_d;
    logic [31:0]    phs_q, phs_d;

    logic           arb_gnt;
    logic           arb_vld;

    rr_arb2 u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .upd_i (state_q == IDLE),
        .gnt_o (arb_gnt),
        .vld_o (arb_vld)
    );

    // State, grant, pointer and operand shadows; reset abandons any sequence.
    always_ff @(posedge clk_cog) begin
        if (res) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            ptr_q   <= 1'b0;
            mask_q  <= 3'b000;
            ctr_q   <= 32'h0;
            frq_q   <= 32'h0;
            phs_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            mask_q  <= mask_d;
            ctr_q   <= ctr_d;
            frq_q   <= frq_d;
            phs_q   <= phs_d;
        end
    end

    // Grant and latch operands in IDLE, then walk the masked write order.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        mask_d  = mask_q;
        ctr_d   = ctr_q;
        frq_d   = frq_q;
        phs_d   = phs_q;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    gnt_d   = arb_gnt;
                    mask_d  = req_mask[arb_gnt];
                    ctr_d   = req_ctr[arb_gnt];
                    frq_d   = req_frq[arb_gnt];
                    phs_d   = req_phs[arb_gnt];
                    state_d = next_step(IDLE, req_mask[arb_gnt], QUIESCE);
                end
            end
            ACK: begin
                ptr_d   = ~gnt_q;
                state_d = IDLE;
            end
            default: begin
                state_d = next_step(state_q, mask_q, QUIESCE);
            end
        endcase
    end

    // Moore decode of strobes, data and ack; data is zero whenever no strobe fires.
    always_comb begin
        ack    = 2'b00;
        setctr = 1'b0;
        setfrq = 1'b0;
        setphs = 1'b0;
        data   = 32'h0;
        case (state_q)
            OFF: begin
                setctr = 1'b1;
                data   = 32'h0;
            end
            FRQ: begin
                setfrq = 1'b1;
                data   = frq_q;
            end
            PHS: begin
                setphs = 1'b1;
                data   = phs_q;
            end
            CTR: begin
                setctr = 1'b1;
                data   = ctr_q;
            end
            ACK: begin
                ack[gnt_q] = 1'b1;
            end
            default: begin
                ack = 2'b00;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign gnt  = busy ? gnt_q : 1'b0;

endmodule
